psum_accum_ctrl: RTL and testbench
==================================

Name: psum_accum_ctrl

Overview:
- Sequencer that time-multiplexes one combinational `adder_tree` instance over a configurable number of input beats (e.g. kernel channels).
- Accumulates the per-beat tree sums into one signed partial sum and returns it on a valid/ready output port.
- Sits between the operand fetch stream and the NPU output/requant stage.

Parameters:
- INPUT_NUM, 15, lanes per beat (tree width)
- INPUT_DATA_WIDTH, 24, signed lane width
- MAX_BEATS, 64, maximum beats per job
- OUT_WIDTH, 32, width of returned sum
- TREE_WIDTH, INPUT_DATA_WIDTH+$clog2(INPUT_NUM), tree output width (derived)
- ACC_WIDTH, TREE_WIDTH+$clog2(MAX_BEATS), internal accumulator width (derived)
- BEAT_W, $clog2(MAX_BEATS)+1, width of cfg_beats (derived)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  job start pulse, sampled only in IDLE
- cfg_beats  in  BEAT_W  beats in job, sampled with start
- cfg_err  out  1  one-cycle pulse when start carries an illegal cfg_beats
- busy  out  1  high in any state other than IDLE
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid&in_ready
- in_data  in  INPUT_NUM*INPUT_DATA_WIDTH  packed signed lanes, lane i at bits [i*W +: W]
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid&out_ready
- out_data  out  OUT_WIDTH  signed accumulated sum
- done  out  1  one-cycle pulse on result handshake

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - All outputs = 0.
  - Stage register, accumulator and beat counters cleared.
  - Reset mid-job abandons the job with no output.
- States:
  - IDLE:
    - start with 1<=cfg_beats<=MAX_BEATS latches cfg_beats, clears beat counters, and moves to RUN.
    - start with cfg_beats==0 or >MAX_BEATS pulses cfg_err the next cycle and stays in IDLE.
  - RUN:
    - in_ready = 1 while accepted_cnt < beats.
    - Each accepted beat is registered into the stage register (s1_valid=1).
    - The following cycle, acc <= (first ? 0 : acc) + sign_ext(tree_sum).
    - Once the last beat is accepted, in_ready drops the same cycle; move to DRAIN.
  - DRAIN: one cycle; performs the final accumulate; move to OUT.
  - OUT:
    - out_valid = 1 and out_data = result; both held stable until out_ready.
    - On the handshake: done pulses, out_valid clears, move to IDLE.
- Latency:
  - Last beat accepted at cycle T -> out_valid at T+2.
  - Back-to-back beats are accepted at 1/cycle; in_valid gaps are allowed.
- start while busy is ignored; no cfg_err.
- Arithmetic is two's complement. ACC_WIDTH cannot overflow for legal cfg_beats.
- Result = low OUT_WIDTH bits of acc, or saturated under the feature below.
- out_valid high with out_ready low: no state change, no new input accepted (in_ready=0).

Optional Feature:
- Macro: PSUM_SAT_EN.
- Defined: result is clamped to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] when acc exceeds that range.
- Undefined: result is truncated to the low OUT_WIDTH bits (wraps).
- Only the final conversion differs; the accumulator is identical in both builds.

Decomposition:
- Package `psum_pkg`:
  - state enum (IDLE, RUN, DRAIN, OUT)
  - width helper constants (TREE_WIDTH and ACC_WIDTH formulas)
  - saturation function for acc -> OUT_WIDTH
- Sub-module: the existing `adder_tree`, instantiated once with INPUT_NUM and INPUT_DATA_WIDTH, fed from the stage register.
- The FSM, counters and accumulator stay in this module.

Test Plan:
- Reset: hold rst_n=0 then release -> busy=0, in_ready=0, out_valid=0, out_data=0, done=0. Assert rst_n=0 during RUN after 2 of 4 beats -> immediate return to IDLE, no out_valid.
- cfg_beats=1, all 15 lanes = 1 -> out_valid 2 cycles after the accept, out_data=15, done pulses on out_ready.
- cfg_beats=4, lanes = -1, in_valid low every other cycle -> out_data=-60 (0xFFFFFFC4), exactly 4 accepts.
- cfg_beats=2, beats of lanes=3 then lanes=-3, out_ready held low 5 cycles, start pulsed while in OUT -> out_data=0 stable, in_ready=0, start ignored, no cfg_err.
- cfg_beats=0, then cfg_beats=65 -> cfg_err pulses once each, busy stays 0.
- cfg_beats=64, all lanes = 8388607:
  - with PSUM_SAT_EN: out_data=0x7FFFFFFF
  - without PSUM_SAT_EN: out_data=0xDFFFFC40

Source files
------------

// File: rtl/psum_accum_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// psum_pkg
// Shared types and helpers for the partial-sum accumulation controller.
//   - state_t        : controller FSM states
//   - tree_width()   : adder-tree output width for n lanes of w bits
//   - acc_width()    : accumulator width for a tree width and a beat limit
//   - sat_to_width() : clamp a signed value into a w-bit signed range
// ---------------------------------------------------------------------------
package psum_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  // Summing n signed w-bit lanes grows the result by clog2(n) bits.
  function automatic int tree_width(input int n, input int w);
    return w + $clog2(n);
  endfunction

  // Accumulating up to max_beats tree sums grows it by clog2(max_beats) bits.
  function automatic int acc_width(input int tw, input int max_beats);
    return tw + $clog2(max_beats);
  endfunction

  // Clamp v into [-2^(w-1), 2^(w-1)-1]; valid for 1 <= w <= 63.
  function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] v,
                                                      input int unsigned       w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 32'd1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 32'd1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/psum_accum_ctrl_if.sv
// ---------------------------------------------------------------------------
// psum_accum_ctrl_if
// Job control, beat input stream and result output stream of the
// partial-sum controller.
//   start/cfg_beats/cfg_err/busy : job control
//   in_valid/in_ready/in_data    : packed signed lanes, lane i at [i*W +: W]
//   out_valid/out_ready/out_data : accumulated signed result
//   done                         : one-cycle pulse after the result handshake
// master drives the job and streams; slave is the controller.
// ---------------------------------------------------------------------------
interface psum_accum_ctrl_if #(
  parameter int INPUT_NUM        = 15,
  parameter int INPUT_DATA_WIDTH = 24,
  parameter int OUT_WIDTH        = 32,
  parameter int BEAT_W           = 7
);
  logic                                  start;
  logic [BEAT_W-1:0]                     cfg_beats;
  logic                                  cfg_err;
  logic                                  busy;
  logic                                  in_valid;
  logic                                  in_ready;
  logic [INPUT_NUM*INPUT_DATA_WIDTH-1:0] in_data;
  logic                                  out_valid;
  logic                                  out_ready;
  logic [OUT_WIDTH-1:0]                  out_data;
  logic                                  done;

  modport master (
    output start, cfg_beats, in_valid, in_data, out_ready,
    input  cfg_err, busy, in_ready, out_valid, out_data, done
  );

  modport slave (
    input  start, cfg_beats, in_valid, in_data, out_ready,
    output cfg_err, busy, in_ready, out_valid, out_data, done
  );
endinterface

// File: rtl/psum_accum_ctrl_adder_tree.sv
// ---------------------------------------------------------------------------
// adder_tree
// Combinational signed sum of INPUT_NUM lanes of INPUT_DATA_WIDTH bits.
//   data_i : packed lanes, lane i at [i*INPUT_DATA_WIDTH +: INPUT_DATA_WIDTH]
//   sum_o  : signed sum, TREE_WIDTH bits (never overflows)
// ---------------------------------------------------------------------------
module adder_tree
  import psum_pkg::*;
#(
  parameter int INPUT_NUM        = 15,
  parameter int INPUT_DATA_WIDTH = 24,
  parameter int TREE_WIDTH       = tree_width(INPUT_NUM, INPUT_DATA_WIDTH)
) (
  input  logic [INPUT_NUM*INPUT_DATA_WIDTH-1:0] data_i,
  output logic signed [TREE_WIDTH-1:0]          sum_o
);

  // Sign-extend each lane to the tree width and sum them.
  always_comb begin
    sum_o = '0;
    for (int i = 0; i < INPUT_NUM; i++) begin
      sum_o = sum_o + {{(TREE_WIDTH-INPUT_DATA_WIDTH){data_i[i*INPUT_DATA_WIDTH+INPUT_DATA_WIDTH-1]}},
                       data_i[i*INPUT_DATA_WIDTH +: INPUT_DATA_WIDTH]};
    end
  end

endmodule

// File: rtl/psum_accum_ctrl.sv
// ---------------------------------------------------------------------------
// psum_accum_ctrl
// Streams cfg_beats beats of packed lanes through one adder_tree and
// accumulates the per-beat sums into a signed partial sum, returned on a
// valid/ready port.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset; abandons any job in flight
//   bus   : psum_accum_ctrl_if.slave (job control, input beats, result)
// Build option: define PSUM_SAT_EN to clamp the result to the signed
// OUT_WIDTH range; otherwise the result wraps to the low OUT_WIDTH bits.
// ---------------------------------------------------------------------------
module psum_accum_ctrl
  import psum_pkg::*;
#(
  parameter int INPUT_NUM        = 15,
  parameter int INPUT_DATA_WIDTH = 24,
  parameter int MAX_BEATS        = 64,
  parameter int OUT_WIDTH        = 32,
  parameter int TREE_WIDTH       = tree_width(INPUT_NUM, INPUT_DATA_WIDTH),
  parameter int ACC_WIDTH        = acc_width(TREE_WIDTH, MAX_BEATS),
  parameter int BEAT_W           = $clog2(MAX_BEATS) + 1
) (
  input logic                clk,
  input logic                rst_n,
  psum_accum_ctrl_if.slave   bus
);

  localparam int DATA_W = INPUT_NUM * INPUT_DATA_WIDTH;

  state_t                       state_q, state_d;
  logic [BEAT_W-1:0]            beats_q, beats_d;
  logic [BEAT_W-1:0]            cnt_q, cnt_d;
  logic                         s1_valid_q, s1_valid_d;
  logic                         s1_first_q, s1_first_d;
  logic [DATA_W-1:0]            s1_data_q, s1_data_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic                         in_ready_q, in_ready_d;
  logic                         out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0]         out_data_q, out_data_d;
  logic                         done_q, done_d;
  logic                         cfg_err_q, cfg_err_d;
  logic                         busy_q, busy_d;

  logic                         accept_s;
  logic                         cfg_ok_s;
  logic                         last_beat_s;
  logic signed [TREE_WIDTH-1:0] tree_sum_s;
  logic signed [ACC_WIDTH-1:0]  tree_ext_s;
  logic [OUT_WIDTH-1:0]         result_s;
`ifdef PSUM_SAT_EN
  logic signed [63:0]           sat_s;
`endif

  adder_tree #(
    .INPUT_NUM        (INPUT_NUM),
    .INPUT_DATA_WIDTH (INPUT_DATA_WIDTH),
    .TREE_WIDTH       (TREE_WIDTH)
  ) u_tree (
    .data_i (s1_data_q),
    .sum_o  (tree_sum_s)
  );

  assign accept_s    = bus.in_valid & in_ready_q;
  assign cfg_ok_s    = (bus.cfg_beats != {BEAT_W{1'b0}}) &&
                       (bus.cfg_beats <= BEAT_W'(MAX_BEATS));
  assign last_beat_s = (BEAT_W'(cnt_q + {{(BEAT_W-1){1'b0}}, 1'b1}) == beats_q);
  assign tree_ext_s  = {{(ACC_WIDTH-TREE_WIDTH){tree_sum_s[TREE_WIDTH-1]}}, tree_sum_s};

  // Final conversion of the next accumulator value into the output width.
  always_comb begin
`ifdef PSUM_SAT_EN
    sat_s    = sat_to_width({{(64-ACC_WIDTH){acc_d[ACC_WIDTH-1]}}, acc_d}, OUT_WIDTH);
    result_s = sat_s[OUT_WIDTH-1:0];
`else
    result_s = acc_d[OUT_WIDTH-1:0];
`endif
  end

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d     = state_q;
    beats_d     = beats_q;
    cnt_d       = cnt_q;
    s1_valid_d  = 1'b0;
    s1_first_d  = s1_first_q;
    s1_data_d   = s1_data_q;
    acc_d       = acc_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    done_d      = 1'b0;
    cfg_err_d   = 1'b0;

    // The first beat of a job restarts the sum instead of adding to stale acc.
    if (s1_valid_q) begin
      acc_d = (s1_first_q ? {ACC_WIDTH{1'b0}} : acc_q) + tree_ext_s;
    end else begin
      acc_d = acc_q;
    end

    if (accept_s) begin
      s1_valid_d = 1'b1;
      s1_first_d = (cnt_q == {BEAT_W{1'b0}});
      s1_data_d  = bus.in_data;
      cnt_d      = BEAT_W'(cnt_q + {{(BEAT_W-1){1'b0}}, 1'b1});
    end else begin
      s1_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (cfg_ok_s) begin
            beats_d    = bus.cfg_beats;
            cnt_d      = {BEAT_W{1'b0}};
            in_ready_d = 1'b1;
            state_d    = ST_RUN;
          end else begin
            cfg_err_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        // in_ready is registered, so it must drop on the edge taking the last beat.
        if (accept_s && last_beat_s) begin
          in_ready_d = 1'b0;
          state_d    = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        out_valid_d = 1'b1;
        out_data_d  = result_s;
        state_d     = ST_OUT;
      end
      ST_OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          done_d      = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_OUT;
        end
      end
      default: begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      beats_q     <= '0;
      cnt_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_data_q   <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      beats_q     <= beats_d;
      cnt_q       <= cnt_d;
      s1_valid_q  <= s1_valid_d;
      s1_first_q  <= s1_first_d;
      s1_data_q   <= s1_data_d;
      acc_q       <= acc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.done      = done_q;
  assign bus.cfg_err   = cfg_err_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_psum_accum_ctrl.sv
// ---------------------------------------------------------------------------
// tb_psum_accum_ctrl
// Directed bench for psum_accum_ctrl with hand-computed expected sums.
// ---------------------------------------------------------------------------
module tb_psum_accum_ctrl;

  localparam int N  = 15;
  localparam int W  = 24;
  localparam int BW = 7;
  localparam int OW = 32;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  psum_accum_ctrl_if #(
    .INPUT_NUM(N), .INPUT_DATA_WIDTH(W), .OUT_WIDTH(OW), .BEAT_W(BW)
  ) bus ();

  psum_accum_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*W-1:0] lanes(input int v);
    logic [N*W-1:0] d;
    logic [W-1:0]   l;
    l = W'(v);
    for (int i = 0; i < N; i++) d[i*W +: W] = l;
    return d;
  endfunction

  task automatic start_job(input int beats);
    bus.start     = 1'b1;
    bus.cfg_beats = BW'(beats);
    tick();
    bus.start     = 1'b0;
  endtask

  task automatic wait_out(input string tag, input int budget);
    for (int i = 0; i < budget && !bus.out_valid; i++) tick();
    chk(tag, {63'd0, bus.out_valid}, 64'd1);
  endtask

  task automatic handshake(input string tag);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({tag, "_done"}, {63'd0, bus.done}, 64'd1);
    chk({tag, "_ovclr"}, {63'd0, bus.out_valid}, 64'd0);
    tick();
    chk({tag, "_done0"}, {63'd0, bus.done}, 64'd0);
    chk({tag, "_idle"}, {63'd0, bus.busy}, 64'd0);
  endtask

  initial begin
    int acc_cnt;
    n_tests       = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.cfg_beats = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_irdy", {63'd0, bus.in_ready}, 64'd0);
    chk("rst_oval", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_odat", {32'd0, bus.out_data}, 64'd0);
    chk("rst_done", {63'd0, bus.done}, 64'd0);
    rst_n = 1'b1;
    tick();

    // One beat of ones: sum 15, out_valid exactly two cycles after accept
    start_job(1);
    chk("t1_busy", {63'd0, bus.busy}, 64'd1);
    chk("t1_irdy", {63'd0, bus.in_ready}, 64'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = lanes(1);
    tick();
    bus.in_valid = 1'b0;
    chk("t1_irdy_drop", {63'd0, bus.in_ready}, 64'd0);
    chk("t1_oval_t1", {63'd0, bus.out_valid}, 64'd0);
    tick();
    chk("t1_oval_t2", {63'd0, bus.out_valid}, 64'd1);
    chk("t1_data", {32'd0, bus.out_data}, 64'd15);
    handshake("t1");

    // Four beats of -1 with in_valid gaps: -60, exactly four accepts
    start_job(4);
    bus.in_data = lanes(-1);
    acc_cnt     = 0;
    for (int c = 0; c < 14; c++) begin
      bus.in_valid = c[0];
      if (bus.in_valid && bus.in_ready) acc_cnt++;
      tick();
    end
    bus.in_valid = 1'b0;
    chk("t2_accepts", 64'(acc_cnt), 64'd4);
    chk("t2_oval", {63'd0, bus.out_valid}, 64'd1);
    chk("t2_data", {32'd0, bus.out_data}, 64'h0000_0000_FFFF_FFC4);
    handshake("t2");

    // +3 then -3 beats, output stalled 5 cycles with a start pulse in OUT
    start_job(2);
    bus.in_valid = 1'b1;
    bus.in_data  = lanes(3);
    tick();
    bus.in_data  = lanes(-3);
    tick();
    bus.in_valid = 1'b0;
    wait_out("t3_oval", 4);
    for (int c = 0; c < 5; c++) begin
      bus.start     = (c == 2);
      bus.cfg_beats = BW'(1);
      bus.in_valid  = 1'b1;
      tick();
      chk("t3_hold_oval", {63'd0, bus.out_valid}, 64'd1);
      chk("t3_hold_data", {32'd0, bus.out_data}, 64'd0);
      chk("t3_hold_irdy", {63'd0, bus.in_ready}, 64'd0);
      chk("t3_hold_cerr", {63'd0, bus.cfg_err}, 64'd0);
    end
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    handshake("t3");

    // Illegal beat counts 0 and 65
    start_job(0);
    chk("t4_err0", {63'd0, bus.cfg_err}, 64'd1);
    chk("t4_busy0", {63'd0, bus.busy}, 64'd0);
    tick();
    chk("t4_err0_clr", {63'd0, bus.cfg_err}, 64'd0);
    start_job(65);
    chk("t4_err65", {63'd0, bus.cfg_err}, 64'd1);
    chk("t4_busy65", {63'd0, bus.busy}, 64'd0);
    tick();
    chk("t4_err65_clr", {63'd0, bus.cfg_err}, 64'd0);
    chk("t4_busy_end", {63'd0, bus.busy}, 64'd0);

    // 64 beats of max positive lanes: 960*8388607 exceeds 32-bit range
    start_job(64);
    bus.in_valid = 1'b1;
    bus.in_data  = lanes(8388607);
    acc_cnt      = 0;
    for (int c = 0; c < 80 && bus.in_ready; c++) begin
      acc_cnt++;
      tick();
    end
    bus.in_valid = 1'b0;
    chk("t5_accepts", 64'(acc_cnt), 64'd64);
    wait_out("t5_oval", 4);
`ifdef PSUM_SAT_EN
    chk("t5_data", {32'd0, bus.out_data}, 64'h0000_0000_7FFF_FFFF);
`else
    chk("t5_data", {32'd0, bus.out_data}, 64'h0000_0000_DFFF_FC40);
`endif
    handshake("t5");

    // Reset after two of four beats abandons the job
    start_job(4);
    bus.in_valid = 1'b1;
    bus.in_data  = lanes(5);
    tick();
    tick();
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t6_busy", {63'd0, bus.busy}, 64'd0);
    chk("t6_irdy", {63'd0, bus.in_ready}, 64'd0);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("t6_no_oval", {63'd0, bus.out_valid}, 64'd0);
    end
    chk("t6_idle", {63'd0, bus.busy}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
